// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer write-port arbiter.
//   FB_HRES/FB_VRES : default frame geometry (640x480, 1 bpp)
//   FB_COORD_W      : width of x/y coordinates
//   fb_pixel_t      : one pixel write (x, y, colour)
//   arb_state_t     : arbiter mode (IDLE arbitration / CLEAR sweep)
package fb_pkg;

  localparam int unsigned FB_HRES    = 640;
  localparam int unsigned FB_VRES    = 480;
  localparam int unsigned FB_COORD_W = 11;

  typedef struct packed {
    logic [FB_COORD_W-1:0] x;
    logic [FB_COORD_W-1:0] y;
    logic                  color;
  } fb_pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   : request vector
//   rr_i    : index with highest priority this cycle
//   grant_o : one-hot grant to the first requester at or above rr_i (mod NREQ)
//   idx_o   : encoded index of the granted requester
//   valid_o : any request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   rr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  logic [PW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(rr_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: owns the framebuffer pixel write port.
//   clk50, reset          : system clock, async active-high reset
//   req/req_x/req_y/req_color : per-client pixel write requests (11-bit packed coords)
//   grant                 : one-hot accept, combinational
//   clear_start/clear_color : start a full-frame fill with the given colour
//   clear_busy/clear_done : fill in progress / final fill pixel issued
//   oob_err               : a granted write was out of frame and dropped
//   fb_x/fb_y/fb_color/fb_write : registered framebuffer write port
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned HRES = FB_HRES,
  parameter int unsigned VRES = FB_VRES
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*FB_COORD_W-1:0] req_x,
  input  logic [NREQ*FB_COORD_W-1:0] req_y,
  input  logic [NREQ-1:0]            req_color,
  output logic [NREQ-1:0]            grant,
  input  logic                       clear_start,
  input  logic                       clear_color,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic                       oob_err,
  output logic [FB_COORD_W-1:0]      fb_x,
  output logic [FB_COORD_W-1:0]      fb_y,
  output logic                       fb_color,
  output logic                       fb_write
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [FB_COORD_W-1:0] X_LAST = FB_COORD_W'(HRES - 1);
  localparam logic [FB_COORD_W-1:0] Y_LAST = FB_COORD_W'(VRES - 1);

  arb_state_t            state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [FB_COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic                  ccol_q, ccol_d;
  fb_pixel_t             pix_q, pix_d;
  logic                  wr_q, wr_d;
  logic                  done_q, done_d;
  logic                  oob_q, oob_d;
  logic                  busy_q, busy_d;

  logic [NREQ-1:0]       arb_grant;
  logic [PW-1:0]         arb_idx;
  logic                  arb_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req_i   (req),
    .rr_i    (rr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    ccol_d  = ccol_q;
    pix_d   = pix_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    oob_d   = 1'b0;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          ccol_d  = clear_color;
          cx_d    = '0;
          cy_d    = '0;
        end else if (arb_valid) begin
          grant       = arb_grant;
          pix_d.x     = req_x[32'(arb_idx)*FB_COORD_W +: FB_COORD_W];
          pix_d.y     = req_y[32'(arb_idx)*FB_COORD_W +: FB_COORD_W];
          pix_d.color = req_color[arb_idx];
          // Out-of-frame writes are still accepted so the client moves on.
          if (pix_d.x > X_LAST || pix_d.y > Y_LAST) begin
            oob_d = 1'b1;
          end else begin
            wr_d = 1'b1;
          end
          rr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
        end
      end
      CLEAR: begin
        pix_d.x     = cx_q;
        pix_d.y     = cy_q;
        pix_d.color = ccol_q;
        wr_d        = 1'b1;
        if (cx_q == X_LAST) begin
          cx_d = '0;
          if (cy_q == Y_LAST) begin
            cy_d    = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cy_d = cy_q + FB_COORD_W'(1);
          end
        end else begin
          cx_d = cx_q + FB_COORD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Busy is registered so it also covers the cycle the last fill pixel lands.
    busy_d = (state_q == CLEAR) || (state_d == CLEAR);
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      ccol_q  <= 1'b0;
      pix_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      ccol_q  <= ccol_d;
      pix_q   <= pix_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      oob_q   <= oob_d;
      busy_q  <= busy_d;
    end
  end

  assign fb_x       = pix_q.x;
  assign fb_y       = pix_q.y;
  assign fb_color   = pix_q.color;
  assign fb_write   = wr_q;
  assign clear_done = done_q;
  assign oob_err    = oob_q;
  assign clear_busy = busy_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter, using a reduced frame so full clear
// sweeps stay short.
module tb_fb_write_arbiter;

  localparam int NREQ = 4;
  localparam int H    = 40;
  localparam int V    = 24;
  localparam int NPIX = H * V;

  logic                 clk50 = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*11-1:0]   req_x = '0;
  logic [NREQ*11-1:0]   req_y = '0;
  logic [NREQ-1:0]      req_color = '0;
  logic [NREQ-1:0]      grant;
  logic                 clear_start = 1'b0;
  logic                 clear_color = 1'b0;
  logic                 clear_busy, clear_done, oob_err;
  logic [10:0]          fb_x, fb_y;
  logic                 fb_color, fb_write;

  fb_write_arbiter #(
    .NREQ (NREQ),
    .HRES (H),
    .VRES (V)
  ) dut (
    .clk50       (clk50),
    .reset       (reset),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .grant       (grant),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .oob_err     (oob_err),
    .fb_x        (fb_x),
    .fb_y        (fb_y),
    .fb_color    (fb_color),
    .fb_write    (fb_write)
  );

  always #10 clk50 = ~clk50;

  typedef struct {
    int x;
    int y;
    bit c;
    bit wr;
    bit oob;
    bit done;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rr_m   = 0;
  bit   busy_exp = 1'b0;
  bit   pend_v[NREQ];
  int   pend_x[NREQ];
  int   pend_y[NREQ];
  bit   pend_c[NREQ];

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Monitor: every framebuffer-side event must match the scoreboard head.
  exp_t mon_e;
  bit   mon_due, mon_bad;
  always begin
    @(posedge clk50);
    #1;
    if (reset !== 1'b1) begin
      mon_due = (q.size() > 0) && (q[0].due == cyc);
      if (fb_write || oob_err || clear_done || mon_due) begin
        checks++;
        if (!mon_due) begin
          errors++;
          $display("FAIL unexpected_out cyc=%0d got w=%0b oob=%0b done=%0b x=%0d y=%0d exp no output",
                   cyc, fb_write, oob_err, clear_done, fb_x, fb_y);
        end else begin
          mon_e   = q.pop_front();
          mon_bad = (fb_write !== mon_e.wr) || (oob_err !== mon_e.oob) || (clear_done !== mon_e.done);
          if (mon_e.wr)
            mon_bad = mon_bad || (fb_x !== 11'(mon_e.x)) || (fb_y !== 11'(mon_e.y)) || (fb_color !== mon_e.c);
          if (mon_bad) begin
            errors++;
            $display("FAIL fb_out cyc=%0d got w=%0b oob=%0b done=%0b x=%0d y=%0d c=%0b exp w=%0b oob=%0b done=%0b x=%0d y=%0d c=%0b",
                     cyc, fb_write, oob_err, clear_done, fb_x, fb_y, fb_color,
                     mon_e.wr, mon_e.oob, mon_e.done, mon_e.x, mon_e.y, mon_e.c);
          end
        end
      end
    end
  end

  // Reference rule: the requester closest at or after rr (circular distance) wins.
  function automatic int pick(input logic [NREQ-1:0] m, input int rr);
    int best, bestd, d;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - rr + NREQ) % NREQ;
      if (m[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input int x, input int y, input bit c);
    pend_v[i] = 1'b1;
    pend_x[i] = x;
    pend_y[i] = y;
    pend_c[i] = c;
  endtask

  task automatic drive_pend();
    for (int i = 0; i < NREQ; i++) begin
      req[i]            = pend_v[i];
      req_x[i*11 +: 11] = 11'(pend_x[i]);
      req_y[i*11 +: 11] = 11'(pend_y[i]);
      req_color[i]      = pend_c[i];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fb_write"}, fb_write, 0);
    chk({tag, "_fb_xy"}, {fb_x, fb_y, fb_color}, 0);
    chk({tag, "_busy"}, clear_busy, 0);
    chk({tag, "_done"}, clear_done, 0);
    chk({tag, "_oob"}, oob_err, 0);
    chk({tag, "_grant"}, grant, 0);
  endtask

  task automatic idle_cycle();
    logic [NREQ-1:0] m;
    int   g;
    exp_t e;
    @(posedge clk50);
    #2;
    clear_start = 1'b0;
    drive_pend();
    m = req;
    #1;
    g = pick(m, rr_m);
    chk("grant", 32'(grant), (g < 0) ? 0 : (1 << g));
    chk("clear_busy", clear_busy, busy_exp);
    if (g >= 0) begin
      e.x    = pend_x[g];
      e.y    = pend_y[g];
      e.c    = pend_c[g];
      e.oob  = (pend_x[g] >= H) || (pend_y[g] >= V);
      e.wr   = !e.oob;
      e.done = 1'b0;
      e.due  = cyc + 1;
      q.push_back(e);
      pend_v[g] = 1'b0;
      rr_m      = (g + 1) % NREQ;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk50);
    #2;
    reset       = 1'b1;
    clear_start = 1'b0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    drive_pend();
    rr_m     = 0;
    busy_exp = 1'b0;
    q.delete();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk50);
    #2;
    reset = 1'b0;
  endtask

  // Fill sweep; abort_at >= 0 asserts reset just before that pixel is issued.
  task automatic clear_sweep(input bit col, input int abort_at);
    exp_t e;
    @(posedge clk50);
    #2;
    clear_start = 1'b1;
    clear_color = col;
    drive_pend();
    #1;
    chk("grant_clear_start", grant, 0);
    for (int k = 0; k < NPIX; k++) begin
      @(posedge clk50);
      #2;
      clear_start = (k == 500);
      clear_color = ~col;
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        q.delete();
        return;
      end
      #1;
      chk("grant_in_clear", grant, 0);
      chk("busy_in_clear", clear_busy, 1);
      e.x    = k % H;
      e.y    = k / H;
      e.c    = col;
      e.wr   = 1'b1;
      e.oob  = 1'b0;
      e.done = (k == NPIX - 1);
      e.due  = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic after_clear();
    busy_exp = 1'b1;
    idle_cycle();
    busy_exp = 1'b0;
    idle_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_x[i] = 0;
      pend_y[i] = 0;
      pend_c[i] = 1'b0;
    end
    apply_reset();

    // Single write from client 0.
    set_req(0, 5, 7, 1'b1);
    idle_cycle();
    idle_cycle();

    // All clients continuously requesting from rr=0.
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i]) set_req(i, $urandom_range(H - 1), $urandom_range(V - 1), 1'($urandom_range(1)));
      idle_cycle();
    end
    idle_cycle();

    // rr=2 with clients 0 and 1, then all four to expose the final rr.
    apply_reset();
    set_req(1, 1, 1, 1'b0);
    idle_cycle();
    set_req(0, 2, 2, 1'b1);
    set_req(1, 3, 3, 1'b0);
    idle_cycle();
    idle_cycle();
    for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 4, 1'b1);
    for (int n = 0; n < NREQ; n++) idle_cycle();

    // Frame boundaries: last in-range column/line and first out-of-range ones.
    set_req(0, H, 0, 1'b1);
    idle_cycle();
    set_req(0, 0, V, 1'b1);
    idle_cycle();
    set_req(0, H - 1, V - 1, 1'b1);
    idle_cycle();
    set_req(2, 2047, 2047, 1'b0);
    idle_cycle();
    idle_cycle();

    // Random traffic including out-of-frame coordinates.
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && $urandom_range(1) == 1)
          set_req(i, $urandom_range(H + 1), $urandom_range(V + 1), 1'($urandom_range(1)));
      idle_cycle();
    end
    for (int n = 0; n < 2 * NREQ; n++) idle_cycle();

    // Clear with client 0 held pending; a second clear_start mid-sweep is ignored.
    apply_reset();
    set_req(0, 5, 6, 1'b0);
    clear_sweep(1'b1, -1);
    after_clear();

    // Reset in the middle of a sweep, then a fresh full sweep.
    clear_sweep(1'b1, 3 * H + 10);
    apply_reset();
    repeat (3) idle_cycle();
    clear_sweep(1'b0, -1);
    after_clear();

    repeat (3) idle_cycle();
    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
